// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system control block: IO command codes,
// reset-generator state encoding and default identification constants.
package sys_ctrl_pkg;

  // IO command address map
  localparam logic [4:0] IOC_MODULE_VER = 5'd0;
  localparam logic [4:0] IOC_SYSTEM_VER = 5'd1;
  localparam logic [4:0] IOC_MANU_ID    = 5'd2;
  localparam logic [4:0] IOC_ERR_STICKY = 5'd3;
  localparam logic [4:0] IOC_SOFT_RST   = 5'd4;
  localparam logic [4:0] IOC_TX_CLR     = 5'd5;
  localparam logic [4:0] IOC_TX_SET     = 5'd6;
  localparam logic [4:0] IOC_ERR_CLR    = 5'd7;
  localparam logic [4:0] IOC_IRQ_MASK   = 5'd8;
  localparam logic [4:0] IOC_TX_STATE   = 5'd9;

  // Default identification constants
  localparam logic [7:0] DEF_MODULE_VER = 8'h02;
  localparam logic [7:0] DEF_SYSTEM_VER = 8'h01;
  localparam logic [7:0] DEF_MANU_ID    = 8'h01;

  // Width of the pulse/holdoff counter (covers RST_LEN up to 255)
  localparam int RST_CNT_W = 8;

  // Soft-reset generator states
  typedef enum logic [1:0] {
    RST_IDLE    = 2'd0,
    RST_PULSE   = 2'd1,
    RST_HOLDOFF = 2'd2
  } rst_state_e;

endpackage

// File: rtl/sys_ctrl_rst_gen.sv
// Soft-reset pulse generator: a fixed-length pulse followed by a holdoff
// window in which further start requests are dropped. Comes out of the
// hardware reset already pulsing so the rest of the FPGA gets a power-on pulse.
module sys_ctrl_rst_gen
  import sys_ctrl_pkg::*;
#(
  parameter int RST_LEN     = 16,
  parameter int HOLDOFF_LEN = 4
) (
  input  logic i_sys_clk,
  input  logic i_rst_b,
  input  logic i_start,
  output logic o_soft_reset
);

  localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RST_LEN - 1);
  localparam logic [RST_CNT_W-1:0] HOLD_LAST = RST_CNT_W'(HOLDOFF_LEN - 1);

  rst_state_e           state;
  rst_state_e           state_nxt;
  logic [RST_CNT_W-1:0] cnt;
  logic [RST_CNT_W-1:0] cnt_nxt;

  // State and counter register; hardware reset restarts the pulse from zero
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state <= RST_PULSE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and pulse output; starts outside IDLE are ignored
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    o_soft_reset = 1'b0;
    case (state)
      RST_IDLE: begin
        if (i_start) begin
          state_nxt = RST_PULSE;
          cnt_nxt   = '0;
        end
      end
      RST_PULSE: begin
        o_soft_reset = 1'b1;
        if (cnt == RST_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (HOLDOFF_LEN == 0) ? RST_IDLE : RST_HOLDOFF;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RST_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sys_ctrl_mc.sv
// System control register block: IO command decode, identification
// registers, per-channel TX/RX state, sticky error flags with interrupt
// mask, and the soft-reset generator. Soft reset does not affect this block.
module sys_ctrl_mc
  import sys_ctrl_pkg::*;
#(
  parameter int         NUM_CH      = 2,
  parameter int         RST_LEN     = 16,
  parameter int         HOLDOFF_LEN = 4,
  parameter int         ERR_W       = 8,
  parameter logic [7:0] MODULE_VER  = DEF_MODULE_VER,
  parameter logic [7:0] SYSTEM_VER  = DEF_SYSTEM_VER,
  parameter logic [7:0] MANU_ID     = DEF_MANU_ID
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_b,
  input  logic [4:0]        i_ioc,
  input  logic [7:0]        i_data_in,
  output logic [7:0]        o_data_out,
  input  logic              i_cs,
  input  logic              i_fetch_cmd,
  input  logic              i_load_cmd,
  output logic              o_soft_reset,
  output logic [NUM_CH-1:0] o_trx_state_tx,
  input  logic [ERR_W-1:0]  i_error_list,
  output logic              o_irq
);

  logic              load_q;
  logic              load_qq;
  logic              fetch_q;
  logic              fetch_qq;
  logic [4:0]        ioc_q;
  logic [7:0]        data_q;
  logic              wr_fire;
  logic              rd_fire;
  logic [NUM_CH-1:0] tx_state;
  logic [ERR_W-1:0]  sticky;
  logic [ERR_W-1:0]  mask;
  logic [ERR_W-1:0]  err_clr;
  logic [7:0]        rd_data;
  logic              rst_start;

  // Sample the strobes, address and data; the second stage gives edge detect
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      load_q   <= 1'b0;
      load_qq  <= 1'b0;
      fetch_q  <= 1'b0;
      fetch_qq <= 1'b0;
      ioc_q    <= '0;
      data_q   <= '0;
    end else begin
      load_q   <= i_cs & i_load_cmd;
      load_qq  <= load_q;
      fetch_q  <= i_cs & i_fetch_cmd;
      fetch_qq <= fetch_q;
      ioc_q    <= i_ioc;
      data_q   <= i_data_in;
    end
  end

  // One-shot actions on the rising edge of each sampled strobe
  always_comb begin
    wr_fire   = load_q & ~load_qq;
    rd_fire   = fetch_q & ~fetch_qq;
    rst_start = wr_fire && (ioc_q == IOC_SOFT_RST);
    err_clr   = '0;
    if (wr_fire && (ioc_q == IOC_ERR_CLR)) begin
      err_clr = data_q[ERR_W-1:0];
    end
  end

  // TX/RX channel state: clear and set commands act only on real channels
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      tx_state <= '0;
    end else if (wr_fire && (ioc_q == IOC_TX_CLR)) begin
      tx_state <= tx_state & ~data_q[NUM_CH-1:0];
    end else if (wr_fire && (ioc_q == IOC_TX_SET)) begin
      tx_state <= tx_state | data_q[NUM_CH-1:0];
    end
  end

  // Sticky errors: a flag still asserted wins over a same-cycle clear
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~err_clr) | i_error_list;
    end
  end

  // Interrupt mask, all sources enabled out of reset
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      mask <= '1;
    end else if (wr_fire && (ioc_q == IOC_IRQ_MASK)) begin
      mask <= data_q[ERR_W-1:0];
    end
  end

  // Interrupt request registered from the current sticky and mask values
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(sticky & mask);
    end
  end

  // Read mux; unmapped addresses read as zero
  always_comb begin
    rd_data = 8'h00;
    case (ioc_q)
      IOC_MODULE_VER: rd_data = MODULE_VER;
      IOC_SYSTEM_VER: rd_data = SYSTEM_VER;
      IOC_MANU_ID:    rd_data = MANU_ID;
      IOC_ERR_STICKY: rd_data = 8'(sticky);
      IOC_IRQ_MASK:   rd_data = 8'(mask);
      IOC_TX_STATE:   rd_data = 8'(tx_state);
      default:        rd_data = 8'h00;
    endcase
  end

  // Read data register, captured alongside any same-cycle write so it sees the old value
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      o_data_out <= 8'h00;
    end else if (rd_fire) begin
      o_data_out <= rd_data;
    end
  end

  assign o_trx_state_tx = tx_state;

  sys_ctrl_rst_gen #(
    .RST_LEN    (RST_LEN),
    .HOLDOFF_LEN(HOLDOFF_LEN)
  ) u_rst_gen (
    .i_sys_clk   (i_sys_clk),
    .i_rst_b     (i_rst_b),
    .i_start     (rst_start),
    .o_soft_reset(o_soft_reset)
  );

endmodule

// File: tb/tb_sys_ctrl_mc.sv
// Directed testbench for sys_ctrl_mc with default parameters.
module tb_sys_ctrl_mc;

  logic       clk;
  logic       rst_b;
  logic [4:0] ioc;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       cs;
  logic       fetch;
  logic       load;
  logic       soft_reset;
  logic [1:0] tx_state;
  logic [7:0] error_list;
  logic       irq;

  int checks = 0;
  int errors = 0;

  sys_ctrl_mc dut (
    .i_sys_clk     (clk),
    .i_rst_b       (rst_b),
    .i_ioc         (ioc),
    .i_data_in     (data_in),
    .o_data_out    (data_out),
    .i_cs          (cs),
    .i_fetch_cmd   (fetch),
    .i_load_cmd    (load),
    .o_soft_reset  (soft_reset),
    .o_trx_state_tx(tx_state),
    .i_error_list  (error_list),
    .o_irq         (irq)
  );

  // 10 ns system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus access starting at a falling edge, holding the strobes for 'hold' cycles
  task automatic applyStimulus(input logic [4:0] a, input logic [7:0] d, input bit rd, input bit wr, input int hold);
    ioc     = a;
    data_in = d;
    cs      = 1'b1;
    fetch   = rd;
    load    = wr;
    repeat (hold) @(negedge clk);
    cs    = 1'b0;
    fetch = 1'b0;
    load  = 1'b0;
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [7:0] d);
    applyStimulus(a, d, 1'b0, 1'b1, 1);
    @(negedge clk);
  endtask

  task automatic doRead(input string tag, input logic [4:0] a, input logic [7:0] exp);
    applyStimulus(a, 8'h00, 1'b1, 1'b0, 1);
    @(negedge clk);
    checkOutput(tag, {24'h0, data_out}, {24'h0, exp});
  endtask

  // Count consecutive falling-edge samples with soft reset high, bounded
  task automatic measurePulse(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (soft_reset !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    while (soft_reset === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst_b      = 1'b0;
    ioc        = '0;
    data_in    = '0;
    cs         = 1'b0;
    fetch      = 1'b0;
    load       = 1'b0;
    error_list = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_soft_reset", {31'h0, soft_reset}, 32'h1);
    checkOutput("rst_tx_state", {30'h0, tx_state}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("rst_data_out", {24'h0, data_out}, 32'h0);

    // Power-on pulse after release
    rst_b = 1'b1;
    measurePulse(n);
    checkOutput("por_pulse_len", n, 16);

    // Identification and unmapped reads
    doRead("rd_module_ver", 5'd0, 8'h02);
    doRead("rd_system_ver", 5'd1, 8'h01);
    doRead("rd_manu_id", 5'd2, 8'h01);
    doRead("rd_unmapped", 5'd20, 8'h00);

    // Channel TX/RX state
    doWrite(5'd6, 8'hFF);
    checkOutput("tx_set_all", {30'h0, tx_state}, 32'h3);
    doWrite(5'd5, 8'h01);
    checkOutput("tx_clr_bit0", {30'h0, tx_state}, 32'h2);
    doRead("rd_tx_state", 5'd9, 8'h02);
    repeat (3) @(negedge clk);
    checkOutput("rd_data_held", {24'h0, data_out}, 32'h02);

    // Sticky errors and W1C
    error_list = 8'h05;
    @(negedge clk);
    error_list = 8'h00;
    @(negedge clk);
    checkOutput("irq_after_err", {31'h0, irq}, 32'h1);
    doRead("rd_sticky_05", 5'd3, 8'h05);
    error_list = 8'h01;
    doWrite(5'd7, 8'h01);
    error_list = 8'h00;
    doRead("rd_sticky_set_wins", 5'd3, 8'h05);
    doWrite(5'd7, 8'h01);
    doRead("rd_sticky_w1c", 5'd3, 8'h04);
    checkOutput("irq_sticky_04", {31'h0, irq}, 32'h1);

    // Mask and interrupt latency
    doWrite(5'd8, 8'h00);
    checkOutput("irq_mask0_lag", {31'h0, irq}, 32'h1);
    @(negedge clk);
    checkOutput("irq_mask0", {31'h0, irq}, 32'h0);
    doRead("rd_mask_00", 5'd8, 8'h00);
    doWrite(5'd8, 8'h04);
    @(negedge clk);
    checkOutput("irq_mask04", {31'h0, irq}, 32'h1);

    // Simultaneous read and write return the pre-write value
    applyStimulus(5'd8, 8'hFF, 1'b1, 1'b1, 1);
    @(negedge clk);
    checkOutput("rd_wr_same_old", {24'h0, data_out}, 32'h04);
    doRead("rd_mask_ff", 5'd8, 8'hFF);

    // Strobe held 10 cycles gives a single pulse
    ioc = 5'd4;
    cs = 1'b1;
    load = 1'b1;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 10) begin
        cs = 1'b0;
        load = 1'b0;
      end
      if (soft_reset === 1'b1) n++;
      else if (n > 0) break;
    end
    checkOutput("held10_pulse_len", n, 16);

    // Command landing two cycles into holdoff is dropped
    applyStimulus(5'd4, 8'h00, 1'b0, 1'b1, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (soft_reset === 1'b1) n++;
    end
    checkOutput("holdoff_dropped", n, 0);

    // Command from idle starts a new pulse
    doWrite(5'd4, 8'h00);
    measurePulse(n);
    checkOutput("idle_pulse_len", n, 16);
    repeat (10) @(negedge clk);

    // Strobe held past holdoff still fires only once
    ioc = 5'd4;
    cs = 1'b1;
    load = 1'b1;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 25) begin
        cs = 1'b0;
        load = 1'b0;
      end
      if (soft_reset === 1'b1) n++;
    end
    checkOutput("held25_single", n, 16);

    // Hardware reset in the middle of a pulse
    doWrite(5'd4, 8'h00);
    n = 0;
    while (soft_reset === 1'b1 && n < 8) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mid_pulse_reached", n, 8);
    rst_b = 1'b0;
    #1;
    checkOutput("mid_rst_soft_reset", {31'h0, soft_reset}, 32'h1);
    checkOutput("mid_rst_tx_state", {30'h0, tx_state}, 32'h0);
    checkOutput("mid_rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("mid_rst_data_out", {24'h0, data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    measurePulse(n);
    checkOutput("mid_rst_pulse_len", n, 16);
    doRead("rd_mask_reset", 5'd8, 8'hFF);
    doRead("rd_sticky_reset", 5'd3, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
